// File: rtl/ov7670_sccb_pkg.sv
// Shared constants, state encoding and frame helper for the OV7670 SCCB configuration master.
// Imported by ov7670_sccb_rom and ov7670_sccb_config.
package ov7670_sccb_pkg;

  typedef logic [2:0] sccb_state_t;

  localparam sccb_state_t S_WAIT_PWR = 3'd0;
  localparam sccb_state_t S_LOAD     = 3'd1;
  localparam sccb_state_t S_START    = 3'd2;
  localparam sccb_state_t S_SEND     = 3'd3;
  localparam sccb_state_t S_STOP     = 3'd4;
  localparam sccb_state_t S_GAP      = 3'd5;
  localparam sccb_state_t S_DONE     = 3'd6;

  localparam logic [7:0]  SCCB_DEV_ID     = 8'h42;
  localparam logic [15:0] SCCB_TERMINATOR = 16'hFFFF;
  localparam logic [7:0]  COM7_ADDR       = 8'h12;
  localparam logic [7:0]  COM7_RESET      = 8'h80;
  localparam logic [4:0]  FRAME_LAST_BIT  = 5'd26;

  // Bit bit_idx (0 = first on the wire) of the 27-bit write frame; every 9th bit is the
  // don't-care slot, driven high.
  function automatic logic sccb_bit(input logic [15:0] entry, input logic [4:0] bit_idx);
    logic [26:0] frame;
    frame = {SCCB_DEV_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
    return frame[FRAME_LAST_BIT - bit_idx];
  endfunction

endpackage

// File: rtl/ov7670_sccb_rom.sv
// Register table for the OV7670: QVGA RGB444 setup, or a 3-entry table when USE_TEST_ROM=1.
// Each entry is {reg_addr, reg_data}; 16'hFFFF ends the table.
module ov7670_sccb_rom
  import ov7670_sccb_pkg::*;
#(
  parameter bit USE_TEST_ROM = 1'b0
) (
  input  logic [7:0]  index_i,
  output logic [15:0] entry_o
);

  // NOTE: pure combinational lookup, so there is no storage here to reset.
  always_comb begin
    entry_o = SCCB_TERMINATOR;
    if (USE_TEST_ROM) begin
      case (index_i)
        8'd0:    entry_o = {COM7_ADDR, COM7_RESET};
        8'd1:    entry_o = 16'h1204;
        default: entry_o = SCCB_TERMINATOR;
      endcase
    end else begin
      case (index_i)
        8'd0:    entry_o = {COM7_ADDR, COM7_RESET};  // soft reset, must stay first
        8'd1:    entry_o = 16'h1204;  // COM7: RGB output
        8'd2:    entry_o = 16'h1100;  // CLKRC: internal clock prescaler
        8'd3:    entry_o = 16'h0C04;  // COM3: enable downsampling
        8'd4:    entry_o = 16'h3E19;  // COM14: PCLK divide, manual scaling
        8'd5:    entry_o = 16'h8C02;  // RGB444 enable, xR GB
        8'd6:    entry_o = 16'h0400;  // COM1
        8'd7:    entry_o = 16'h40D0;  // COM15: full output range
        8'd8:    entry_o = 16'h3A04;  // TSLB
        8'd9:    entry_o = 16'h1438;  // COM9: AGC ceiling
        8'd10:   entry_o = 16'h4FB3;  // colour matrix
        8'd11:   entry_o = 16'h50B3;
        8'd12:   entry_o = 16'h5100;
        8'd13:   entry_o = 16'h523D;
        8'd14:   entry_o = 16'h53A7;
        8'd15:   entry_o = 16'h54E4;
        8'd16:   entry_o = 16'h589E;
        8'd17:   entry_o = 16'h3DC0;  // COM13: gamma, UV auto adjust
        8'd18:   entry_o = 16'h1716;  // HSTART
        8'd19:   entry_o = 16'h1804;  // HSTOP
        8'd20:   entry_o = 16'h3224;  // HREF
        8'd21:   entry_o = 16'h1902;  // VSTART
        8'd22:   entry_o = 16'h1A7A;  // VSTOP
        8'd23:   entry_o = 16'h030A;  // VREF
        8'd24:   entry_o = 16'h7011;  // scaling X
        8'd25:   entry_o = 16'h7135;  // scaling Y
        8'd26:   entry_o = 16'h7211;  // downsample by 2
        8'd27:   entry_o = 16'h73F1;  // DSP clock divide
        8'd28:   entry_o = 16'hA202;  // pixel clock delay
        8'd29:   entry_o = 16'h1E00;  // MVFP: no mirror/flip
        default: entry_o = SCCB_TERMINATOR;
      endcase
    end
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// OV7670 SCCB write master: walks the register ROM once after power-up, and again on start.
// Define SCCB_RESET_DELAY_EN to stretch the gap after the COM7 soft-reset write to RST_DELAY.
module ov7670_sccb_config
  import ov7670_sccb_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 250,
  parameter int unsigned PWR_DELAY    = 1_000_000,
  parameter int unsigned GAP_CYCLES   = 4 * CLK_DIV,
  parameter int unsigned RST_DELAY    = 1_000_000,
  parameter bit          USE_TEST_ROM = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic SCL,
  output logic SDA,
  output logic busy,
  output logic done
);

  localparam int unsigned WAIT_MAX0 = (PWR_DELAY > GAP_CYCLES) ? PWR_DELAY : GAP_CYCLES;
  localparam int unsigned WAIT_MAX  = (WAIT_MAX0 > RST_DELAY) ? WAIT_MAX0 : RST_DELAY;
  localparam int          WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam int          DIV_W     = $clog2(CLK_DIV + 1);

  localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'(PWR_DELAY - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'(GAP_CYCLES - 1);
`ifdef SCCB_RESET_DELAY_EN
  localparam logic [WAIT_W-1:0] RST_LAST = WAIT_W'(RST_DELAY - 1);
`endif
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  sccb_state_t       state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        qtr_q, qtr_d;
  logic [4:0]        bit_q, bit_d;
  logic              scl_q, scl_d;
  logic              sda_q, sda_d;

  logic [15:0]       entry;
  logic [WAIT_W-1:0] gap_last;
  logic              in_bus;
  logic              tick;
  logic              phase_entry;

  ov7670_sccb_rom #(
    .USE_TEST_ROM(USE_TEST_ROM)
  ) u_rom (
    .index_i(idx_q),
    .entry_o(entry)
  );

  assign in_bus = (state_q == S_START) || (state_q == S_SEND) || (state_q == S_STOP);
  assign tick   = in_bus && (div_q == DIV_LAST);

`ifdef SCCB_RESET_DELAY_EN
  assign gap_last = (entry == {COM7_ADDR, COM7_RESET}) ? RST_LAST : GAP_LAST;
`else
  assign gap_last = GAP_LAST;
`endif

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    bit_d       = bit_q;
    phase_entry = 1'b0;
    case (state_q)
      S_WAIT_PWR: begin
        if (wait_q == PWR_LAST) begin
          state_d = S_LOAD;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (entry == SCCB_TERMINATOR || idx_q == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          state_d     = S_START;
          phase_entry = 1'b1;
        end
      end
      S_START: begin
        if (tick && qtr_q == 2'd1) begin
          state_d     = S_SEND;
          bit_d       = '0;
          phase_entry = 1'b1;
        end
      end
      S_SEND: begin
        if (tick && qtr_q == 2'd3) begin
          if (bit_q == FRAME_LAST_BIT) begin
            state_d     = S_STOP;
            phase_entry = 1'b1;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end
      S_STOP: begin
        if (tick && qtr_q == 2'd1) begin
          state_d = S_GAP;
          wait_d  = '0;
        end
      end
      S_GAP: begin
        if (wait_q == gap_last) begin
          state_d = S_LOAD;
          wait_d  = '0;
          idx_d   = idx_q + 8'd1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      default: state_d = S_WAIT_PWR;
    endcase
  end

  // Quarter timing restarts on every phase entry; idle states hold it at zero.
  always_comb begin
    div_d = '0;
    qtr_d = '0;
    if (in_bus && !phase_entry) begin
      if (tick) begin
        qtr_d = qtr_q + 2'd1;
      end else begin
        div_d = div_q + 1'b1;
        qtr_d = qtr_q;
      end
    end
  end

  // Pins are decoded from next-state values so they are registered yet aligned with the state.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_d)
      S_START: begin
        sda_d = 1'b0;
        scl_d = (qtr_d == 2'd0);
      end
      S_SEND: begin
        scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_d = sccb_bit(entry, bit_d);
      end
      S_STOP: begin
        sda_d = 1'b0;
        scl_d = (qtr_d == 2'd1);
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT_PWR;
      idx_q   <= '0;
      wait_q  <= '0;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  assign SCL  = scl_q;
  assign SDA  = sda_q;
  assign busy = (state_q != S_DONE);
  assign done = (state_q == S_DONE);

endmodule
